hazard_control_unit: RTL and testbench

Pipeline hazard controller for the 5-stage (IF, ID, EX, MEM, WB) LEGv8 core. Tracks the destination register, write-enable and load flag of the instructions in EX and MEM. From these it drives the forwarding-mux selects for the ID-stage operands, stalls IF/ID on load-use hazards, and flushes IF/ID on taken ID-stage branches. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_control_unit.sv | 90 +++++++++
 tb/tb_hazard_control_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - LEGv8 5-stage hazard controller: forwarding selects, load-use stall, branch flush, event counters
module hazard_control_unit #(
    parameter int REG_BITS  = 5,
    parameter int ZERO_REG  = 31,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_BITS-1:0]  id_Rn,
    input  logic [REG_BITS-1:0]  id_Rm,
    input  logic                 id_uses_Rn,
    input  logic                 id_uses_Rm,
    input  logic [REG_BITS-1:0]  id_Rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_br_taken,
    output logic                 pc_write_en,
    output logic                 ifid_write_en,
    output logic                 idex_bubble,
    output logic                 flush_ifid,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [REG_BITS-1:0]  ZERO    = REG_BITS'(ZERO_REG);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_BITS-1:0] ex_Rd;
    logic                mem_valid, mem_reg_write;
    logic [REG_BITS-1:0] mem_Rd;

    logic ex_hit_rn, ex_hit_rm, mem_hit_rn, mem_hit_rm;
    logic stall, flush;

    // XZR is never a real producer, so it must never match
    assign ex_hit_rn  = id_uses_Rn & ex_valid & ex_reg_write & (ex_Rd == id_Rn) & (id_Rn != ZERO);
    assign ex_hit_rm  = id_uses_Rm & ex_valid & ex_reg_write & (ex_Rd == id_Rm) & (id_Rm != ZERO);
    assign mem_hit_rn = id_uses_Rn & mem_valid & mem_reg_write & (mem_Rd == id_Rn) & (id_Rn != ZERO);
    assign mem_hit_rm = id_uses_Rm & mem_valid & mem_reg_write & (mem_Rd == id_Rm) & (id_Rm != ZERO);

    assign stall = id_valid & ex_mem_read & (ex_hit_rn | ex_hit_rm);
    assign flush = id_valid & id_br_taken & ~stall;

    assign pc_write_en   = ~stall;
    assign ifid_write_en = ~stall;
    assign idex_bubble   = stall;
    assign flush_ifid    = flush;

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_hit_rn)       fwd_a_sel = 2'b01;
        else if (mem_hit_rn) fwd_a_sel = 2'b10;
        if (ex_hit_rm)       fwd_b_sel = 2'b01;
        else if (mem_hit_rm) fwd_b_sel = 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_Rd         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_Rd        <= '0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_Rd        <= ex_Rd;
            if (stall) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_Rd        <= id_Rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
            if (stall && stall_count != CNT_MAX) stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush && flush_count != CNT_MAX) flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit (8-bit counters to reach saturation quickly)
module tb_hazard_control_unit;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0, id_uses_Rn = 1'b0, id_uses_Rm = 1'b0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0, id_br_taken = 1'b0;
    logic [4:0]    id_Rn = '0, id_Rm = '0, id_Rd = '0;
    logic          pc_write_en, ifid_write_en, idex_bubble, flush_ifid;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_count, flush_count;

    hazard_control_unit #(.REG_BITS(5), .ZERO_REG(31), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm),
        .id_uses_Rn(id_uses_Rn), .id_uses_Rm(id_uses_Rm), .id_Rd(id_Rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_br_taken(id_br_taken),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .idex_bubble(idex_bubble),
        .flush_ifid(flush_ifid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef logic [8+2*CW-1:0] resp_t;
    resp_t exp_q[$];
    string name_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;

    // Inputs change 1 time unit after the rising edge; the expected response is queued then.
    task automatic d(input logic rst, input logic v, input logic [4:0] rn, input logic [4:0] rm,
                     input logic urn, input logic urm, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic br, input logic pc, input logic ifd,
                     input logic bub, input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [CW-1:0] sc, input logic [CW-1:0] fc, input string nm);
        @(posedge clk);
        #1;
        reset = rst; id_valid = v; id_Rn = rn; id_Rm = rm; id_uses_Rn = urn; id_uses_Rm = urm;
        id_Rd = rd; id_reg_write = rw; id_mem_read = mr; id_br_taken = br;
        exp_q.push_back({pc, ifd, bub, fl, fa, fb, sc, fc});
        name_q.push_back(nm);
    endtask

    // Monitor: the DUT presents a response every cycle; compare on the falling edge.
    initial begin
        resp_t act, exp_v;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act   = {pc_write_en, ifid_write_en, idex_bubble, flush_ifid, fwd_a_sel, fwd_b_sel, stall_count, flush_count};
                tests_run++;
                if (act !== exp_v) begin
                    tests_failed++;
                    $display("FAIL %s: got pc=%b ifid=%b bub=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d, expected pc=%b ifid=%b bub=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d",
                             nm, act[2*CW+7], act[2*CW+6], act[2*CW+5], act[2*CW+4], act[2*CW+3 -: 2], act[2*CW+1 -: 2], act[2*CW-1 -: CW], act[CW-1:0],
                             exp_v[2*CW+7], exp_v[2*CW+6], exp_v[2*CW+5], exp_v[2*CW+4], exp_v[2*CW+3 -: 2], exp_v[2*CW+1 -: 2], exp_v[2*CW-1 -: CW], exp_v[CW-1:0]);
                end
            end
        end
    end

    initial begin
        int cnt;
        int guard;
        //  rst v  rn  rm  urn urm rd  rw mr br   pc if bu fl fa    fb    sc fc
        d(1, 0, 0,  0,  0, 0,  0,  0, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "reset_state");
        // ADD X2 ; ADD X3,X2,X1 ; unrelated ; ADD X11,X3,X1
        d(0, 1, 0,  1,  1, 1,  2,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "add_x2");
        d(0, 1, 2,  1,  1, 1,  3,  1, 0, 0,   1, 1, 0, 0, 2'b01, 2'b00, 0, 0, "fwd_ex_rn");
        d(0, 1, 8,  9,  1, 1,  7,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "unrelated");
        d(0, 1, 3,  1,  1, 1, 11,  1, 0, 0,   1, 1, 0, 0, 2'b10, 2'b00, 0, 0, "fwd_mem_rn");
        // LDUR X5 ; SUB X6,X1,X5 stalls once then forwards from MEM
        d(0, 1, 1,  0,  1, 0,  5,  1, 1, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "ldur_x5");
        d(0, 1, 1,  5,  1, 1,  6,  1, 0, 0,   0, 0, 1, 0, 2'b00, 2'b01, 0, 0, "load_use_stall");
        d(0, 1, 1,  5,  1, 1,  6,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b10, 1, 0, "load_use_release");
        // XZR writers never hazard
        d(0, 1, 1,  2,  1, 1, 31,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 0, "adds_xzr");
        d(0, 1, 0,  0,  1, 0, 31,  1, 1, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 0, "ldur_xzr");
        d(0, 1, 31, 31, 1, 1, 12,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 0, "xzr_reader");
        // X4 in EX and MEM: EX wins on both operands
        d(0, 1, 1,  1,  1, 1,  4,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 0, "add_x4_a");
        d(0, 1, 1,  1,  1, 1,  4,  1, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 0, "add_x4_b");
        d(0, 1, 4,  4,  1, 1, 13,  1, 0, 0,   1, 1, 0, 0, 2'b01, 2'b01, 1, 0, "ex_priority");
        // Taken CBZ without hazard, then CBZ on a just-loaded register
        d(0, 1, 0, 20,  0, 1,  0,  0, 0, 1,   1, 1, 0, 1, 2'b00, 2'b00, 1, 0, "cbz_flush");
        d(0, 1, 0,  0,  0, 0,  0,  0, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 1, "flush_one_cycle");
        d(0, 1, 1,  0,  1, 0,  9,  1, 1, 0,   1, 1, 0, 0, 2'b00, 2'b00, 1, 1, "ldur_x9");
        d(0, 1, 0,  9,  0, 1,  0,  0, 0, 1,   0, 0, 1, 0, 2'b00, 2'b01, 1, 1, "cbz_stalled");
        d(0, 1, 0,  9,  0, 1,  0,  0, 0, 1,   1, 1, 0, 1, 2'b00, 2'b10, 2, 1, "cbz_late_flush");
        d(0, 0, 0,  0,  0, 0,  0,  0, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 2, 2, "idle");
        // LDUR X5,[X5] repeated stalls on every other cycle; push stall_count into saturation
        cnt = 2;
        for (int i = 0; i < 2 * ((1 << CW) + 3) + 1; i++) begin
            if (i % 2 == 1) begin
                d(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, 0, 2'b01, 2'b00, CW'(cnt), 2, "sat_stall");
                if (cnt < (1 << CW) - 1) cnt++;
            end else begin
                d(0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 1, 1, 0, 0, (i == 0) ? 2'b00 : 2'b10, 2'b00, CW'(cnt), 2, "sat_run");
            end
        end
        d(0, 1, 5, 0, 1, 0, 5, 1, 1, 0,   0, 0, 1, 0, 2'b01, 2'b00, 8'hFF, 2, "sat_hold");
        d(0, 1, 5, 0, 1, 0, 5, 1, 1, 0,   1, 1, 0, 0, 2'b10, 2'b00, 8'hFF, 2, "sat_run_last");
        // Reset asserted mid-cycle while a load-use stall is set up
        d(1, 1, 5, 0, 1, 0, 5, 1, 1, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "reset_mid_stall");
        d(0, 1, 5, 0, 1, 0, 5, 1, 1, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "after_reset");
        d(0, 1, 5, 0, 1, 0, 5, 1, 1, 0,   0, 0, 1, 0, 2'b01, 2'b00, 0, 0, "after_reset_stall");
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: %0d responses pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
